ysyx_25050148_idu_pipe: RTL and testbench
=========================================

# ysyx_25050148_idu_pipe

Pipelined, parametrised successor of the single-cycle decode unit for the ysyx_25050148 core. It sits between IFU and EXU and decodes RV32I/RV32E instructions into a registered control/operand bundle. It owns the integer register file and a per-register pending-write scoreboard, so it stalls on RAW hazards. Valid/ready handshakes on both sides let IFU, EXU and WBU run decoupled.

## Interface
Parameters:
- REG_NUM, 32: architectural registers; 32 (RV32I) or 16 (RV32E); register index width RA_W = $clog2(REG_NUM).
- SB_W, 2: scoreboard counter width; max outstanding writes per register = 2^SB_W-1.

Ports (reset is asynchronous, active-low):
- clk  in  1  core clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  IFU offers an instruction.
- in_ready  out  1  IDU accepts this cycle.
- in_pc  in  32  instruction PC.
- in_inst  in  32  instruction word.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  EXU accepts the bundle.
- out_pc, out_src1, out_src2, out_imm  out  32 each  PC, rs1/rs2 values, sign-extended immediate.
- out_rd  out  5  destination index.
- out_alu_opt  out  4  ALU op, same encoding as the current IDU (0 add, 1 sub, 3 and, 4 or, 5 xor, 6 cmp, 7 eq, 8 sll, 9 srl/sra, 15 none).
- out_left_opt, out_right_opt  out  2 each  operand selects (left 0 src1/1 pc/2 imm; right 0 imm/1 const 4/2 src2/3 zero).
- out_pc_jump  out  3  0 jal, 1 jalr, 2 branch, 3 ecall/mret, 4 none.
- out_func3  out  3;  out_reg_wen, out_mem_wen, out_mem_ren, out_ebreak, out_illegal  out  1 each.
- wb_en  in  1;  wb_addr  in  5;  wb_data  in  32  write-back port.
- flush  in  1  kill the held bundle (taken branch/trap).

## Operation
- Decode is combinational from in_inst; accepted bundle is registered into a single output stage.
- Source usage: rs1 used by R/I/S/B types; rs2 by R/S/B. Index 0 or unused source never hazards.
- Hazard when a used source has sb[rs]!=0, or when reg_wen && rd!=0 && sb[rd]==2^SB_W-1 (saturation).
- in_ready = !hazard && (!out_valid || out_ready) && !flush.
- Accept (in_valid && in_ready): load output stage; if reg_wen && rd!=0, sb[rd]+=1.
- wb_en && wb_addr!=0: write regfile, sb[wb_addr]-=1. Same-cycle inc and dec on the same index: net unchanged.
- With REG_NUM=16, rs1/rs2/rd/wb_addr bit 4 set, or an unknown opcode: out_illegal=1, reg_wen=0, mem_wen=0, no scoreboard change.
- flush: clears out_valid next cycle and undoes the held bundle's scoreboard increment (suppressed if out_ready fires the same cycle). No accept that cycle.
- ebreak (0x00100073): out_ebreak=1. Simulation finish is the consumer's job.
- Register x0 reads 0, and writes to it are ignored.

## Timing
- Reset: out_valid=0, all out_* = 0, all sb=0, regfile all 0, in_ready follows the combinational rule.
- Latency: accept in cycle N produces out_valid in cycle N+1. One bundle per cycle is sustained when there is no hazard.
- Output holds stable while out_valid && !out_ready.
- Reset mid-operation: any held bundle and all pending counts are discarded immediately.

## Configuration
- YSYX_25050148_IDU_BYPASS_EN defined: a write-back in the same cycle to a source with sb==1 clears that hazard, and wb_data is forwarded into out_src1/out_src2. A dependent instruction is accepted in the write-back cycle.
- Undefined: the hazard clears only after the write-back edge, so the dependent instruction is accepted one cycle later. The regfile is read only after it has been written.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with out_ready=1 -> out_valid next cycle, out_imm=5, alu_opt=0, sb[1]=1; wb x1=5 -> sb[1]=0.
- addi x1 then add x2,x1,x1 back-to-back -> in_ready=0 until wb x1. With BYPASS_EN, accepted in the wb cycle with out_src1=out_src2=5. Without it, accepted one cycle later.
- out_ready=0 for 3 cycles with a bundle held -> outputs stable, in_ready=0. Release -> next bundle follows in 1 cycle.
- Four writes to x3 without wb (SB_W=2) -> the fourth stalls at sb[3]=3. One wb -> it is accepted.
- flush with a held lui x5 -> out_valid=0 next cycle, sb[5] returns to 0. Same-cycle flush and out_ready -> sb[5] stays 1.
- REG_NUM=16, add x17,x1,x2 -> out_illegal=1, reg_wen=0, no stall.

Source files
------------

// File: rtl/ysyx_25050148_idu_pipe.sv
// ysyx_25050148_idu_pipe -- pipelined RV32I/RV32E decode stage.
//
// Decodes the instruction offered by the IFU into a single registered
// control/operand bundle for the EXU. Owns the integer register file and a
// per-register pending-write scoreboard, and stalls the IFU on RAW hazards.
//
// Optional feature macro: YSYX_25050148_IDU_BYPASS_EN
//   defined   : a write-back landing in the same cycle on a source whose only
//               pending write is that write-back clears the hazard, and
//               wb_data is forwarded into the registered operand.
//   undefined : a dependent instruction waits until the write-back edge has
//               updated the register file, then reads it normally.
//
// Decode notes: SYSTEM instructions other than ecall/mret/ebreak, and
// reserved func3 encodings of branch/load/store/jalr, are flagged illegal.
// Illegal instructions never write, never touch the scoreboard and never stall.

module ysyx_25050148_idu_pipe #(
    parameter int REG_NUM = 32,
    parameter int SB_W    = 2
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,

    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_src1,
    output logic [31:0] out_src2,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic [3:0]  out_alu_opt,
    output logic [1:0]  out_left_opt,
    output logic [1:0]  out_right_opt,
    output logic [2:0]  out_pc_jump,
    output logic [2:0]  out_func3,
    output logic        out_reg_wen,
    output logic        out_mem_wen,
    output logic        out_mem_ren,
    output logic        out_ebreak,
    output logic        out_illegal,

    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,

    input  logic        flush
);

    localparam int              RA_W   = $clog2(REG_NUM);
    localparam logic [SB_W-1:0] SB_MAX = '1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd3,
        ALU_OR   = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_CMP  = 4'd6,
        ALU_EQ   = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SR   = 4'd9,
        ALU_NONE = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        L_SRC1 = 2'd0,
        L_PC   = 2'd1,
        L_IMM  = 2'd2
    } left_sel_e;

    typedef enum logic [1:0] {
        R_IMM  = 2'd0,
        R_FOUR = 2'd1,
        R_SRC2 = 2'd2,
        R_ZERO = 2'd3
    } right_sel_e;

    typedef enum logic [2:0] {
        PJ_JAL    = 3'd0,
        PJ_JALR   = 3'd1,
        PJ_BRANCH = 3'd2,
        PJ_TRAP   = 3'd3,
        PJ_NONE   = 3'd4
    } pc_jump_e;

    typedef struct packed {
        logic [31:0] imm;
        alu_op_e     alu_opt;
        left_sel_e   left_opt;
        right_sel_e  right_opt;
        pc_jump_e    pc_jump;
        logic        reg_wen;
        logic        mem_wen;
        logic        mem_ren;
        logic        ebreak;
        logic        illegal;
        logic        use_rs1;
        logic        use_rs2;
    } dec_t;

    // ALU operation of OP/OP-IMM from func3; sub only exists on register ops.
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic sub);
        case (f3)
            3'b000:  return sub ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_CMP;
            3'b011:  return ALU_CMP;
            3'b100:  return ALU_XOR;
            3'b101:  return ALU_SR;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Field extraction
    // ------------------------------------------------------------------
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = in_inst[6:0];
    assign func3  = in_inst[14:12];
    assign rs1    = in_inst[19:15];
    assign rs2    = in_inst[24:20];
    assign rd     = in_inst[11:7];

    assign imm_i = {{20{in_inst[31]}}, in_inst[31:20]};
    assign imm_s = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
    assign imm_b = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
    assign imm_u = {in_inst[31:12], 12'b0};
    assign imm_j = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

    logic [RA_W-1:0] rs1_idx, rs2_idx, rd_idx, wb_idx, held_idx;

    assign rs1_idx  = rs1[RA_W-1:0];
    assign rs2_idx  = rs2[RA_W-1:0];
    assign rd_idx   = rd[RA_W-1:0];
    assign wb_idx   = wb_addr[RA_W-1:0];
    assign held_idx = out_rd[RA_W-1:0];

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    dec_t dec, dec_f;

    // Raw opcode decode into the control bundle.
    always_comb begin
        // NOTE: every field gets a default before the case so no path leaves a
        // field unassigned; otherwise synthesis would infer a latch.
        dec           = '0;
        dec.alu_opt   = ALU_NONE;
        dec.left_opt  = L_SRC1;
        dec.right_opt = R_ZERO;
        dec.pc_jump   = PJ_NONE;
        case (opcode)
            OP_LUI: begin
                dec.imm       = imm_u;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_IMM;
                dec.right_opt = R_ZERO;
                dec.reg_wen   = 1'b1;
            end
            OP_AUIPC: begin
                dec.imm       = imm_u;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_PC;
                dec.right_opt = R_IMM;
                dec.reg_wen   = 1'b1;
            end
            OP_JAL: begin
                dec.imm       = imm_j;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_PC;
                dec.right_opt = R_FOUR;
                dec.pc_jump   = PJ_JAL;
                dec.reg_wen   = 1'b1;
            end
            OP_JALR: begin
                dec.imm       = imm_i;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_PC;
                dec.right_opt = R_FOUR;
                dec.pc_jump   = PJ_JALR;
                dec.reg_wen   = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.illegal   = (func3 != 3'b000);
            end
            OP_BRANCH: begin
                dec.imm       = imm_b;
                dec.alu_opt   = (func3[2:1] == 2'b00) ? ALU_EQ : ALU_CMP;
                dec.left_opt  = L_SRC1;
                dec.right_opt = R_SRC2;
                dec.pc_jump   = PJ_BRANCH;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
                dec.illegal   = (func3[2:1] == 2'b01);
            end
            OP_LOAD: begin
                dec.imm       = imm_i;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_SRC1;
                dec.right_opt = R_IMM;
                dec.mem_ren   = 1'b1;
                dec.reg_wen   = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.illegal   = (func3 == 3'b011) || (func3[2:1] == 2'b11);
            end
            OP_STORE: begin
                dec.imm       = imm_s;
                dec.alu_opt   = ALU_ADD;
                dec.left_opt  = L_SRC1;
                dec.right_opt = R_IMM;
                dec.mem_wen   = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
                dec.illegal   = (func3 > 3'b010);
            end
            OP_IMM: begin
                dec.imm       = imm_i;
                dec.alu_opt   = alu_from_f3(func3, 1'b0);
                dec.left_opt  = L_SRC1;
                dec.right_opt = R_IMM;
                dec.reg_wen   = 1'b1;
                dec.use_rs1   = 1'b1;
            end
            OP_REG: begin
                dec.alu_opt   = alu_from_f3(func3, in_inst[30]);
                dec.left_opt  = L_SRC1;
                dec.right_opt = R_SRC2;
                dec.reg_wen   = 1'b1;
                dec.use_rs1   = 1'b1;
                dec.use_rs2   = 1'b1;
            end
            OP_FENCE: begin
                dec.alu_opt = ALU_NONE;
            end
            OP_SYSTEM: begin
                if (in_inst == INST_EBREAK) begin
                    dec.ebreak = 1'b1;
                end else if (in_inst == INST_ECALL || in_inst == INST_MRET) begin
                    dec.pc_jump = PJ_TRAP;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            default: begin
                dec.illegal = 1'b1;
            end
        endcase
    end

    // Register indices beyond x15 are illegal on RV32E, but only in fields the
    // instruction actually uses (U/J immediates overlap the rs1/rs2 fields).
    logic rv32e_bad;

    assign rv32e_bad = (REG_NUM == 16) &&
                       ((dec.use_rs1 && rs1[4]) || (dec.use_rs2 && rs2[4]) ||
                        (dec.reg_wen && rd[4]));

    // Illegal instructions are neutered: no writes, no sources, no scoreboard.
    always_comb begin
        dec_f = dec;
        if (rv32e_bad) begin
            dec_f.illegal = 1'b1;
        end
        if (dec_f.illegal) begin
            dec_f.reg_wen = 1'b0;
            dec_f.mem_wen = 1'b0;
            dec_f.mem_ren = 1'b0;
            dec_f.use_rs1 = 1'b0;
            dec_f.use_rs2 = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Register file, scoreboard and hazard detection
    // ------------------------------------------------------------------
    logic [31:0]     rf      [REG_NUM];
    logic [SB_W-1:0] sb      [REG_NUM];
    logic [SB_W-1:0] sb_next [REG_NUM];

    logic wb_fire;
    assign wb_fire = wb_en && (wb_addr != 5'd0) && ((RA_W == 5) || !wb_addr[4]);

    logic rs1_busy, rs2_busy, rd_full, hazard;

`ifdef YSYX_25050148_IDU_BYPASS_EN
    // A source whose only pending write is landing this cycle is not a hazard.
    assign rs1_busy = dec_f.use_rs1 && (rs1 != 5'd0) && (sb[rs1_idx] != '0) &&
                      !(wb_fire && (wb_addr == rs1) && (sb[rs1_idx] == SB_W'(1)));
    assign rs2_busy = dec_f.use_rs2 && (rs2 != 5'd0) && (sb[rs2_idx] != '0) &&
                      !(wb_fire && (wb_addr == rs2) && (sb[rs2_idx] == SB_W'(1)));
`else
    assign rs1_busy = dec_f.use_rs1 && (rs1 != 5'd0) && (sb[rs1_idx] != '0);
    assign rs2_busy = dec_f.use_rs2 && (rs2 != 5'd0) && (sb[rs2_idx] != '0);
`endif

    assign rd_full = dec_f.reg_wen && (rd != 5'd0) && (sb[rd_idx] == SB_MAX);
    assign hazard  = rs1_busy || rs2_busy || rd_full;

    logic accept, inc_en, undo_en;

    assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign inc_en   = accept && dec_f.reg_wen && (rd != 5'd0);
    // A flushed bundle never reaches write-back, so its pending count is
    // returned -- unless the EXU took it in the same cycle.
    assign undo_en  = flush && out_valid && !out_ready && out_reg_wen && (out_rd != 5'd0);

    logic [31:0] rf_rs1, rf_rs2, src1_val, src2_val;

    assign rf_rs1 = (rs1_idx == '0) ? 32'd0 : rf[rs1_idx];
    assign rf_rs2 = (rs2_idx == '0) ? 32'd0 : rf[rs2_idx];

`ifdef YSYX_25050148_IDU_BYPASS_EN
    assign src1_val = (wb_fire && (wb_addr == rs1)) ? wb_data : rf_rs1;
    assign src2_val = (wb_fire && (wb_addr == rs2)) ? wb_data : rf_rs2;
`else
    assign src1_val = rf_rs1;
    assign src2_val = rf_rs2;
`endif

    // Next scoreboard counts: accept increments, write-back and flush-undo
    // decrement; an increment and decrement on the same index cancel.
    always_comb begin
        for (int i = 0; i < REG_NUM; i++) begin
            // NOTE: blocking assignments here chain the three updates within
            // one evaluation; sequential blocks below use non-blocking only.
            sb_next[i] = sb[i];
            if (inc_en && (rd_idx == RA_W'(i))) begin
                sb_next[i] = sb_next[i] + 1'b1;
            end
            if (wb_fire && (wb_idx == RA_W'(i)) && (sb_next[i] != '0)) begin
                sb_next[i] = sb_next[i] - 1'b1;
            end
            if (undo_en && (held_idx == RA_W'(i)) && (sb_next[i] != '0)) begin
                sb_next[i] = sb_next[i] - 1'b1;
            end
        end
    end

    // Scoreboard register; reset discards every pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) begin
                // NOTE: non-blocking assignment for all sequential state, so
                // every flop samples pre-edge values regardless of block order.
                sb[i] <= '0;
            end
        end else begin
            for (int i = 0; i < REG_NUM; i++) begin
                sb[i] <= sb_next[i];
            end
        end
    end

    // Register file write port; x0 is never written and reads as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: this array is reset deliberately (architectural state must
            // read zero after reset), which keeps it in flops rather than RAM.
            for (int i = 0; i < REG_NUM; i++) begin
                rf[i] <= 32'd0;
            end
        end else if (wb_fire) begin
            rf[wb_idx] <= wb_data;
        end
    end

    // ------------------------------------------------------------------
    // Output stage
    // ------------------------------------------------------------------

    // Single output register: flush kills, accept loads, EXU handshake drains.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid     <= 1'b0;
            out_pc        <= 32'd0;
            out_src1      <= 32'd0;
            out_src2      <= 32'd0;
            out_imm       <= 32'd0;
            out_rd        <= 5'd0;
            out_alu_opt   <= 4'd0;
            out_left_opt  <= 2'd0;
            out_right_opt <= 2'd0;
            out_pc_jump   <= 3'd0;
            out_func3     <= 3'd0;
            out_reg_wen   <= 1'b0;
            out_mem_wen   <= 1'b0;
            out_mem_ren   <= 1'b0;
            out_ebreak    <= 1'b0;
            out_illegal   <= 1'b0;
        end else if (flush) begin
            // in_ready is low during flush, so no accept competes here.
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_pc        <= in_pc;
            out_src1      <= src1_val;
            out_src2      <= src2_val;
            out_imm       <= dec_f.imm;
            out_rd        <= rd;
            out_alu_opt   <= dec_f.alu_opt;
            out_left_opt  <= dec_f.left_opt;
            out_right_opt <= dec_f.right_opt;
            out_pc_jump   <= dec_f.pc_jump;
            out_func3     <= func3;
            out_reg_wen   <= dec_f.reg_wen;
            out_mem_wen   <= dec_f.mem_wen;
            out_mem_ren   <= dec_f.mem_ren;
            out_ebreak    <= dec_f.ebreak;
            out_illegal   <= dec_f.illegal;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ysyx_25050148_idu_pipe.sv
// Directed self-checking bench for ysyx_25050148_idu_pipe.
// Instantiates an RV32I build and an RV32E (REG_NUM=16) build on one clock.

module tb_ysyx_25050148_idu_pipe;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // RV32I instance signals
    logic        in_valid, in_ready, out_valid, out_ready, flush;
    logic [31:0] in_pc, in_inst;
    logic [31:0] out_pc, out_src1, out_src2, out_imm;
    logic [4:0]  out_rd;
    logic [3:0]  out_alu_opt;
    logic [1:0]  out_left_opt, out_right_opt;
    logic [2:0]  out_pc_jump, out_func3;
    logic        out_reg_wen, out_mem_wen, out_mem_ren, out_ebreak, out_illegal;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    // RV32E instance signals
    logic        e_in_valid, e_in_ready, e_out_valid, e_out_ready, e_flush;
    logic [31:0] e_in_pc, e_in_inst;
    logic [31:0] e_out_pc, e_out_src1, e_out_src2, e_out_imm;
    logic [4:0]  e_out_rd;
    logic [3:0]  e_out_alu_opt;
    logic [1:0]  e_out_left_opt, e_out_right_opt;
    logic [2:0]  e_out_pc_jump, e_out_func3;
    logic        e_out_reg_wen, e_out_mem_wen, e_out_mem_ren, e_out_ebreak, e_out_illegal;
    logic        e_wb_en;
    logic [4:0]  e_wb_addr;
    logic [31:0] e_wb_data;

    ysyx_25050148_idu_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_src1(out_src1), .out_src2(out_src2), .out_imm(out_imm), .out_rd(out_rd),
        .out_alu_opt(out_alu_opt), .out_left_opt(out_left_opt), .out_right_opt(out_right_opt),
        .out_pc_jump(out_pc_jump), .out_func3(out_func3), .out_reg_wen(out_reg_wen),
        .out_mem_wen(out_mem_wen), .out_mem_ren(out_mem_ren), .out_ebreak(out_ebreak),
        .out_illegal(out_illegal),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .flush(flush)
    );

    ysyx_25050148_idu_pipe #(.REG_NUM(16), .SB_W(2)) dut_e (
        .clk(clk), .rst(rst),
        .in_valid(e_in_valid), .in_ready(e_in_ready), .in_pc(e_in_pc), .in_inst(e_in_inst),
        .out_valid(e_out_valid), .out_ready(e_out_ready), .out_pc(e_out_pc),
        .out_src1(e_out_src1), .out_src2(e_out_src2), .out_imm(e_out_imm), .out_rd(e_out_rd),
        .out_alu_opt(e_out_alu_opt), .out_left_opt(e_out_left_opt),
        .out_right_opt(e_out_right_opt), .out_pc_jump(e_out_pc_jump), .out_func3(e_out_func3),
        .out_reg_wen(e_out_reg_wen), .out_mem_wen(e_out_mem_wen), .out_mem_ren(e_out_mem_ren),
        .out_ebreak(e_out_ebreak), .out_illegal(e_out_illegal),
        .wb_en(e_wb_en), .wb_addr(e_wb_addr), .wb_data(e_wb_data), .flush(e_flush)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; registered outputs are
    // checked there, combinational in_ready at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;  // addi x1,x0,5
    localparam logic [31:0] I_ADD_X2     = 32'h0010_8133;  // add  x2,x1,x1
    localparam logic [31:0] I_SUB_X4     = 32'h4020_8233;  // sub  x4,x1,x2
    localparam logic [31:0] I_SW         = 32'h0020_A423;  // sw   x2,8(x1)
    localparam logic [31:0] I_BEQ        = 32'hFE20_8EE3;  // beq  x1,x2,-4
    localparam logic [31:0] I_LUI_X5     = 32'h1234_52B7;  // lui  x5,0x12345
    localparam logic [31:0] I_ADD_X6     = 32'h0002_8333;  // add  x6,x5,x0
    localparam logic [31:0] I_ADDI_X3    = 32'h0010_0193;  // addi x3,x0,1
    localparam logic [31:0] I_EBREAK     = 32'h0010_0073;
    localparam logic [31:0] I_JAL_X1_8   = 32'h0080_00EF;  // jal  x1,8
    localparam logic [31:0] I_ADD_X17    = 32'h0020_88B3;  // add  x17,x1,x2
    localparam logic [31:0] I_ADD_X4     = 32'h0020_8233;  // add  x4,x1,x2

    initial begin
        rst = 1'b0;
        in_valid = 1'b0; in_pc = 32'd0; in_inst = 32'd0; out_ready = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0; flush = 1'b0;
        e_in_valid = 1'b0; e_in_pc = 32'd0; e_in_inst = 32'd0; e_out_ready = 1'b0;
        e_wb_en = 1'b0; e_wb_addr = 5'd0; e_wb_data = 32'd0; e_flush = 1'b0;

        // ---------------- reset state
        tick();
        tick();
        settle();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_imm",   out_imm, 32'd0);
        check("rst_alu_opt",   32'(out_alu_opt), 32'd0);
        check("rst_pc_jump",   32'(out_pc_jump), 32'd0);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        tick();
        rst = 1'b1;

        // ---------------- addi x1,x0,5
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_pc     = 32'h8000_0000;
        in_inst   = I_ADDI_X1_5;
        settle();
        check("addi_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("addi_out_valid", 32'(out_valid), 32'd1);
        check("addi_out_imm",   out_imm, 32'd5);
        check("addi_alu_opt",   32'(out_alu_opt), 32'd0);
        check("addi_out_rd",    32'(out_rd), 32'd1);
        check("addi_reg_wen",   32'(out_reg_wen), 32'd1);
        check("addi_out_pc",    out_pc, 32'h8000_0000);
        check("addi_pc_jump",   32'(out_pc_jump), 32'd4);
        check("addi_src1",      out_src1, 32'd0);

        // ---------------- RAW: add x2,x1,x1 waits for wb x1
        in_pc   = 32'h8000_0004;
        in_inst = I_ADD_X2;
        settle();
        check("raw_stall_0", 32'(in_ready), 32'd0);
        tick();
        check("raw_bubble", 32'(out_valid), 32'd0);
        settle();
        check("raw_stall_1", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd1; wb_data = 32'd5;
`ifdef YSYX_25050148_IDU_BYPASS_EN
        settle();
        check("raw_ready_wb_cycle", 32'(in_ready), 32'd1);
        tick();
        wb_en = 1'b0;
`else
        settle();
        check("raw_ready_wb_cycle", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        settle();
        check("raw_ready_after_wb", 32'(in_ready), 32'd1);
        tick();
`endif
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_src1",      out_src1, 32'd5);
        check("add_src2",      out_src2, 32'd5);
        check("add_rd",        32'(out_rd), 32'd2);
        check("add_right_opt", 32'(out_right_opt), 32'd2);
        in_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'd10;
        tick();
        wb_en = 1'b0;

        // ---------------- back-to-back sub / sw / beq
        in_valid = 1'b1;
        in_pc    = 32'h8000_0010;
        in_inst  = I_SUB_X4;
        settle();
        check("sub_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("sub_alu_opt", 32'(out_alu_opt), 32'd1);
        check("sub_src1",    out_src1, 32'd5);
        check("sub_src2",    out_src2, 32'd10);
        in_inst = I_SW;
        settle();
        check("sw_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("sw_out_valid", 32'(out_valid), 32'd1);
        check("sw_mem_wen",   32'(out_mem_wen), 32'd1);
        check("sw_reg_wen",   32'(out_reg_wen), 32'd0);
        check("sw_imm",       out_imm, 32'd8);
        check("sw_func3",     32'(out_func3), 32'd2);
        check("sw_src2",      out_src2, 32'd10);
        in_inst = I_BEQ;
        tick();
        check("beq_out_valid", 32'(out_valid), 32'd1);
        check("beq_alu_opt",   32'(out_alu_opt), 32'd7);
        check("beq_imm",       out_imm, 32'hFFFF_FFFC);
        check("beq_pc_jump",   32'(out_pc_jump), 32'd2);

        // ---------------- backpressure: hold beq for 3 cycles
        out_ready = 1'b0;
        in_pc     = 32'h8000_0020;
        in_inst   = I_LUI_X5;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("hold_in_ready", 32'(in_ready), 32'd0);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_out_imm",   out_imm, 32'hFFFF_FFFC);
        end
        out_ready = 1'b1;
        settle();
        check("release_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("lui_out_valid", 32'(out_valid), 32'd1);
        check("lui_imm",       out_imm, 32'h1234_5000);
        check("lui_left_opt",  32'(out_left_opt), 32'd2);
        check("lui_right_opt", 32'(out_right_opt), 32'd3);
        check("lui_out_pc",    out_pc, 32'h8000_0020);

        // ---------------- flush of held lui x5 returns sb[5] to 0
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b1;
        settle();
        check("flush_in_ready", 32'(in_ready), 32'd0);
        tick();
        flush = 1'b0;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        in_inst = I_ADD_X6;
        settle();
        check("flush_sb5_clear", 32'(in_ready), 32'd1);

        // ---------------- flush together with out_ready keeps sb[5]=1
        tick();
        in_valid = 1'b1;
        in_inst  = I_LUI_X5;
        tick();
        in_valid  = 1'b0;
        flush     = 1'b1;
        out_ready = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_rdy_out_valid", 32'(out_valid), 32'd0);
        in_inst = I_ADD_X6;
        settle();
        check("flush_rdy_sb5_kept", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234_5000;
        tick();
        wb_en = 1'b0;
        settle();
        check("wb_x5_clears", 32'(in_ready), 32'd1);
        tick();

        // ---------------- scoreboard saturation on x3
        in_valid = 1'b1;
        in_inst  = I_ADDI_X3;
        for (int k = 0; k < 3; k++) begin
            settle();
            check("sat_accept", 32'(in_ready), 32'd1);
            tick();
        end
        settle();
        check("sat_stall", 32'(in_ready), 32'd0);
        tick();
        check("sat_bubble", 32'(out_valid), 32'd0);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'd1;
        settle();
        check("sat_stall_wb_cycle", 32'(in_ready), 32'd0);
        tick();
        wb_en = 1'b0;
        settle();
        check("sat_release", 32'(in_ready), 32'd1);
        tick();
        check("sat_out_valid", 32'(out_valid), 32'd1);
        check("sat_out_rd",    32'(out_rd), 32'd3);

        // ---------------- ebreak, unknown opcode, jal
        in_inst = I_EBREAK;
        tick();
        check("ebreak_flag",    32'(out_ebreak), 32'd1);
        check("ebreak_illegal", 32'(out_illegal), 32'd0);
        check("ebreak_alu_opt", 32'(out_alu_opt), 32'd15);
        check("ebreak_reg_wen", 32'(out_reg_wen), 32'd0);
        in_inst = 32'hFFFF_FFFF;
        tick();
        check("unknown_illegal", 32'(out_illegal), 32'd1);
        check("unknown_reg_wen", 32'(out_reg_wen), 32'd0);
        check("unknown_ebreak",  32'(out_ebreak), 32'd0);
        in_inst = I_JAL_X1_8;
        tick();
        check("jal_imm",       out_imm, 32'd8);
        check("jal_pc_jump",   32'(out_pc_jump), 32'd0);
        check("jal_left_opt",  32'(out_left_opt), 32'd1);
        check("jal_right_opt", 32'(out_right_opt), 32'd1);
        check("jal_illegal",   32'(out_illegal), 32'd0);

        // ---------------- reset mid-operation with a bundle held
        out_ready = 1'b0;
        in_inst   = I_LUI_X5;
        tick();
        check("midrst_held", 32'(out_valid), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_imm",   out_imm, 32'd0);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;

        // ---------------- RV32E build: x17 is illegal
        e_in_valid  = 1'b1;
        e_out_ready = 1'b1;
        e_in_inst   = I_ADD_X17;
        settle();
        check("e_x17_in_ready", 32'(e_in_ready), 32'd1);
        tick();
        check("e_x17_out_valid", 32'(e_out_valid), 32'd1);
        check("e_x17_illegal",   32'(e_out_illegal), 32'd1);
        check("e_x17_reg_wen",   32'(e_out_reg_wen), 32'd0);
        e_in_inst = I_ADD_X4;
        tick();
        check("e_x4_illegal", 32'(e_out_illegal), 32'd0);
        check("e_x4_reg_wen", 32'(e_out_reg_wen), 32'd1);
        check("e_x4_rd",      32'(e_out_rd), 32'd4);
        e_in_valid = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
